// File: rtl/mc_control_ext.sv
// rtl/mc_control_ext.sv - multi-cycle MIPS main control FSM with lw/sw/R/beq/bne/addi/j and MemReady waits
// Optional exception path (EPCWrite port, EXCEPT state) enabled by defining MC_CTRL_EXCEPT_EN.
module mc_control_ext #(
    parameter int              OP_W     = 6,
    parameter logic [OP_W-1:0] OP_LW    = 6'b100011,
    parameter logic [OP_W-1:0] OP_SW    = 6'b101011,
    parameter logic [OP_W-1:0] OP_RTYPE = 6'b000000,
    parameter logic [OP_W-1:0] OP_BEQ   = 6'b000100,
    parameter logic [OP_W-1:0] OP_BNE   = 6'b000101,
    parameter logic [OP_W-1:0] OP_ADDI  = 6'b001000,
    parameter logic [OP_W-1:0] OP_J     = 6'b000010
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    input  logic            Zero,
    input  logic            MemReady,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemtoReg,
    output logic            IRWrite,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic            PCSel
`ifdef MC_CTRL_EXCEPT_EN
    ,
    output logic            EPCWrite
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMRDEND = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC     = 4'd6,
        S_RTYPEEND = 4'd7,
        S_ADDIEX   = 4'd8,
        S_ADDIEND  = 4'd9,
        S_BEQ      = 4'd10,
        S_BNE      = 4'd11,
        S_JUMP     = 4'd12
`ifdef MC_CTRL_EXCEPT_EN
        ,
        S_EXCEPT   = 4'd13
`endif
    } state_t;

    state_t state;
    state_t state_next;

    logic pc_write;
    logic pc_write_cond;
    logic branch_ne;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = S_FETCH;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemtoReg      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
`ifdef MC_CTRL_EXCEPT_EN
        EPCWrite      = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                ALUSrcB = 2'b11;
                if (Op == OP_LW || Op == OP_SW) begin
                    state_next = S_MEMADR;
                end else if (Op == OP_RTYPE) begin
                    state_next = S_EXEC;
                end else if (Op == OP_BEQ) begin
                    state_next = S_BEQ;
                end else if (Op == OP_BNE) begin
                    state_next = S_BNE;
                end else if (Op == OP_ADDI) begin
                    state_next = S_ADDIEX;
                end else if (Op == OP_J) begin
                    state_next = S_JUMP;
                end else begin
`ifdef MC_CTRL_EXCEPT_EN
                    state_next = S_EXCEPT;
`else
                    state_next = S_FETCH;
`endif
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Op == OP_LW) begin
                    state_next = S_MEMRD;
                end else if (Op == OP_SW) begin
                    state_next = S_MEMWR;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                state_next = MemReady ? S_MEMRDEND : S_MEMRD;
            end
            S_MEMRDEND: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                state_next = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                state_next = S_RTYPEEND;
            end
            S_RTYPEEND: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = S_ADDIEND;
            end
            S_ADDIEND: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                pc_write_cond = 1'b1;
                PCSource      = 2'b01;
                state_next    = S_FETCH;
            end
            S_BNE: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                pc_write_cond = 1'b1;
                branch_ne     = 1'b1;
                PCSource      = 2'b01;
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                PCSource   = 2'b10;
                state_next = S_FETCH;
            end
`ifdef MC_CTRL_EXCEPT_EN
            S_EXCEPT: begin
                // ALU computes PC-4 (PC already advanced in FETCH) for the EPC.
                ALUSrcB    = 2'b01;
                ALUOp      = 2'b01;
                EPCWrite   = 1'b1;
                PCSource   = 2'b11;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign PCSel = pc_write | (pc_write_cond & (Zero ^ branch_ne));

endmodule

// File: tb/tb_mc_control_ext.sv
// tb/tb_mc_control_ext.sv - randomized self-checking bench for mc_control_ext
// Expected control words come from per-instruction step lists built from the ISA rules.
module tb_mc_control_ext;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = 6'd0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, PCSel;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       epc;
    logic [15:0] obs;

    int total = 0;
    int passed = 0;

    logic [5:0]  q_op[$];
    logic        q_zero[$];
    logic        q_mr[$];
    logic [15:0] q_exp[$];
    string       q_tag[$];

    mc_control_ext dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .PCSel(PCSel)
`ifdef MC_CTRL_EXCEPT_EN
        , .EPCWrite(epc)
`endif
    );

`ifndef MC_CTRL_EXCEPT_EN
    assign epc = 1'b0;
`endif

    assign obs = {IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource, PCSel, epc};

    always #5 clk = ~clk;

    function automatic logic [15:0] cw(input logic iord, input logic mrd, input logic mwr,
                                       input logic m2r, input logic irw, input logic rdst,
                                       input logic rw, input logic srca, input logic [1:0] srcb,
                                       input logic [1:0] aluop, input logic [1:0] pcsrc,
                                       input logic pcsel, input logic epcw);
        return {iord, mrd, mwr, m2r, irw, rdst, rw, srca, srcb, aluop, pcsrc, pcsel, epcw};
    endfunction

    task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: got %h expected %h", tag, o, e);
    endtask

    task automatic push(input logic [5:0] op, input logic z, input logic mr,
                        input logic [15:0] e, input string tag);
        q_op.push_back(op);
        q_zero.push_back(z);
        q_mr.push_back(mr);
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // One instruction from fetch to retirement; Op is only meaningful in DECODE and MEMADR.
    task automatic build_instr(input logic [5:0] op, input int fstall, input int mstall,
                               input logic zfix, input bit use_zfix);
        logic z;
        for (int i = 0; i < fstall; i++)
            push(junk(), rb(), 1'b0, cw(0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0), "fetch_wait");
        push(junk(), rb(), 1'b1, cw(0,1,0,0,1,0,0,0,2'b01,2'b00,2'b00,1,0), "fetch");
        push(op, rb(), rb(), cw(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0), "decode");
        z = use_zfix ? zfix : rb();
        case (op)
            OP_LW: begin
                push(op, rb(), rb(), cw(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), "lw_adr");
                for (int i = 0; i < mstall; i++)
                    push(junk(), rb(), 1'b0, cw(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), "lw_rd_wait");
                push(junk(), rb(), 1'b1, cw(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), "lw_rd");
                push(junk(), rb(), rb(), cw(0,0,0,1,0,0,1,0,2'b00,2'b00,2'b00,0,0), "lw_wb");
            end
            OP_SW: begin
                push(op, rb(), rb(), cw(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), "sw_adr");
                for (int i = 0; i < mstall; i++)
                    push(junk(), rb(), 1'b0, cw(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), "sw_wr_wait");
                push(junk(), rb(), 1'b1, cw(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), "sw_wr");
            end
            OP_RTYPE: begin
                push(junk(), rb(), rb(), cw(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0), "r_exec");
                push(junk(), rb(), rb(), cw(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0), "r_wb");
            end
            OP_ADDI: begin
                push(junk(), rb(), rb(), cw(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), "addi_exec");
                push(junk(), rb(), rb(), cw(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0), "addi_wb");
            end
            OP_BEQ:
                push(junk(), z, rb(), cw(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,z,0), "beq");
            OP_BNE:
                push(junk(), z, rb(), cw(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,!z,0), "bne");
            OP_J:
                push(junk(), rb(), rb(), cw(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0), "jump");
            default: begin
`ifdef MC_CTRL_EXCEPT_EN
                push(junk(), rb(), rb(), cw(0,0,0,0,0,0,0,0,2'b01,2'b01,2'b11,1,1), "except");
`endif
            end
        endcase
    endtask

    task automatic run_queue();
        while (q_exp.size() > 0) begin
            @(negedge clk);
            Op       = q_op.pop_front();
            Zero     = q_zero.pop_front();
            MemReady = q_mr.pop_front();
            #1;
            check(q_tag.pop_front(), obs, q_exp.pop_front());
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [8];
        logic [5:0] o;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J, 6'b111111};
        o = ops[$urandom_range(7)];
        if (o == 6'b111111) begin
            do o = 6'($urandom);
            while (o == OP_LW || o == OP_SW || o == OP_RTYPE || o == OP_BEQ ||
                   o == OP_BNE || o == OP_ADDI || o == OP_J);
        end
        return o;
    endfunction

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        MemReady = 1'b0;
        #1;
        check("reset_fetch", obs, cw(0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0));

        // Reset while a load waits in MEMRD must abandon it without a register write.
        push(junk(), 1'b0, 1'b1, cw(0,1,0,0,1,0,0,0,2'b01,2'b00,2'b00,1,0), "fetch");
        push(OP_LW, 1'b0, 1'b0, cw(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0), "decode");
        push(OP_LW, 1'b0, 1'b0, cw(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), "lw_adr");
        push(junk(), 1'b0, 1'b0, cw(1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0), "lw_rd_wait");
        run_queue();
        @(negedge clk);
        reset = 1'b1;
        MemReady = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        MemReady = 1'b0;
        #1;
        check("midlw_reset_fetch", obs, cw(0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0));
        check("midlw_no_regwrite", {15'd0, RegWrite}, 16'd0);

        build_instr(OP_LW, 0, 0, 1'b0, 1'b0);
        build_instr(OP_SW, 0, 3, 1'b0, 1'b0);
        build_instr(OP_BEQ, 0, 0, 1'b1, 1'b1);
        build_instr(OP_BNE, 0, 0, 1'b1, 1'b1);
        build_instr(OP_BNE, 0, 0, 1'b0, 1'b1);
        build_instr(OP_BEQ, 1, 0, 1'b0, 1'b1);
        build_instr(OP_J, 0, 0, 1'b0, 1'b0);
        build_instr(OP_ADDI, 0, 0, 1'b0, 1'b0);
        build_instr(OP_RTYPE, 2, 0, 1'b0, 1'b0);
        build_instr(6'b111111, 0, 0, 1'b0, 1'b0);
        build_instr(OP_LW, 0, 0, 1'b0, 1'b0);
        run_queue();

        for (int n = 0; n < 60; n++) begin
            build_instr(pick_op(), $urandom_range(2), $urandom_range(3), 1'b0, 1'b0);
            run_queue();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
